// File: rtl/uart_tx_engine.sv
// UART transmit engine: holding-register handshake, shift register and frame
// sequencer, paced by the baud generator's oversample tick.
module uart_tx_engine #(
  parameter  int DATA_W_MAX = 9,
  parameter  int OVS        = 16,
  localparam int CW         = $clog2(DATA_W_MAX + 1)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  tx_en,
  input  logic                  os_tick,
  input  logic [CW-1:0]         cfg_dbits,
  input  logic [2:0]            cfg_par,
  input  logic [1:0]            cfg_stop,
  input  logic                  cfg_brk,
  input  logic                  s_valid,
  input  logic [DATA_W_MAX-1:0] s_data,
  output logic                  s_ready,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int            OW        = $clog2(2 * OVS);
  localparam logic [OW-1:0] LEN_1     = OW'(OVS - 1);
  localparam logic [OW-1:0] LEN_1P5   = OW'((3 * OVS) / 2 - 1);
  localparam logic [OW-1:0] LEN_2     = OW'(2 * OVS - 1);
  localparam logic [CW-1:0] DBITS_MIN = CW'(5);
  localparam logic [CW-1:0] DBITS_MAX = CW'(DATA_W_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                state, state_n;
  logic [OW-1:0]         os_cnt, os_cnt_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_W_MAX-1:0] shift_q, shift_n;
  logic [CW-1:0]         dbits_q, dbits_n;
  logic                  par_en_q, par_en_n;
  logic                  par_bit_q, par_bit_n;
  logic [1:0]            stop_q, stop_n;
  logic                  txd_n, done_n;
  logic [OW-1:0]         len_m1;
  logic                  bit_end, accept;
  logic [CW-1:0]         dbits_eff;
  logic                  data_xor;

  // Bit timing, handshake, and the clamped word length / parity of the offered word.
  always_comb begin
    len_m1 = LEN_1;
    if (state == STOP) begin
      if (stop_q[1])      len_m1 = LEN_2;
      else if (stop_q[0]) len_m1 = LEN_1P5;
    end
    bit_end = os_tick && (os_cnt == len_m1) && (state inside {START, DATA, PARITY, STOP});
    s_ready = tx_en && !cfg_brk && ((state == IDLE) || ((state == STOP) && bit_end));
    accept  = s_valid && s_ready;

    if (cfg_dbits < DBITS_MIN)      dbits_eff = DBITS_MIN;
    else if (cfg_dbits > DBITS_MAX) dbits_eff = DBITS_MAX;
    else                            dbits_eff = cfg_dbits;

    data_xor = 1'b0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (CW'(i) < dbits_eff) data_xor = data_xor ^ s_data[i];
    end
  end

  // Frame sequencer; txd is registered, so it is derived from the next state.
  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    dbits_n   = dbits_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    stop_n    = stop_q;
    done_n    = 1'b0;
    txd_n     = 1'b1;

    if ((state != IDLE) && !tx_en) begin
      state_n   = IDLE;
      os_cnt_n  = '0;
      bit_cnt_n = '0;
    end else if (accept) begin
      state_n   = START;
      os_cnt_n  = '0;
      bit_cnt_n = '0;
      shift_n   = s_data;
      dbits_n   = dbits_eff;
      par_en_n  = cfg_par[2];
      par_bit_n = cfg_par[1] ? ~cfg_par[0] : (cfg_par[0] ? data_xor : ~data_xor);
      stop_n    = cfg_stop;
      done_n    = (state == STOP);
    end else begin
      case (state)
        IDLE:  if (cfg_brk && tx_en) state_n = BREAK;
        BREAK: if (!cfg_brk)         state_n = IDLE;
        START, DATA, PARITY, STOP: begin
          if (os_tick) os_cnt_n = bit_end ? '0 : os_cnt + 1'b1;
          if (bit_end) begin
            case (state)
              START: state_n = DATA;
              DATA: begin
                shift_n = {1'b0, shift_q[DATA_W_MAX-1:1]};
                if (bit_cnt == dbits_q - 1'b1) begin
                  bit_cnt_n = '0;
                  state_n   = par_en_q ? PARITY : STOP;
                end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
                end
              end
              PARITY: state_n = STOP;
              default: begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            endcase
          end
        end
        default: state_n = IDLE;
      endcase
    end

    case (state_n)
      START, BREAK: txd_n = 1'b0;
      DATA:         txd_n = shift_n[0];
      PARITY:       txd_n = par_bit_n;
      default:      txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      dbits_q   <= DBITS_MIN;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 2'b00;
      txd       <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_q   <= shift_n;
      dbits_q   <= dbits_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      stop_q    <= stop_n;
      txd       <= txd_n;
      tx_done   <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a tick-indexed frame model checked every cycle,
// plus directed frames with hand-computed bit sequences and timings.
module tb_uart_tx_engine;

  localparam int DATA_W_MAX = 9;
  localparam int OVS        = 16;
  localparam int CW         = $clog2(DATA_W_MAX + 1);
  localparam int M_IDLE     = 0;
  localparam int M_FRAME    = 1;
  localparam int M_BRK      = 2;

  logic                  pclk = 1'b0;
  logic                  preset, tx_en, os_tick, cfg_brk, s_valid;
  logic [CW-1:0]         cfg_dbits;
  logic [2:0]            cfg_par;
  logic [1:0]            cfg_stop;
  logic [DATA_W_MAX-1:0] s_data;
  logic                  s_ready, txd, busy, tx_done;

  int checks = 0;
  int errors = 0;

  int          m_mode = M_IDLE;
  int          m_ticks = 0;
  int          m_total = 0;
  int          m_nb = 0;
  logic [15:0] m_bits = '0;
  logic        m_done = 1'b0;
  logic        started = 1'b0;

  uart_tx_engine #(.DATA_W_MAX(DATA_W_MAX), .OVS(OVS)) dut (
    .pclk(pclk), .preset(preset), .tx_en(tx_en), .os_tick(os_tick),
    .cfg_dbits(cfg_dbits), .cfg_par(cfg_par), .cfg_stop(cfg_stop), .cfg_brk(cfg_brk),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .txd(txd),
    .busy(busy), .tx_done(tx_done)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic brk, input logic [CW-1:0] dbits,
                               input logic [2:0] par, input logic [1:0] stop,
                               input logic valid, input logic [DATA_W_MAX-1:0] data);
    tx_en = en; cfg_brk = brk; cfg_dbits = dbits; cfg_par = par; cfg_stop = stop;
    s_valid = valid; s_data = data;
  endtask

  function automatic int eff_dbits(input logic [CW-1:0] d);
    if (int'(d) < 5) return 5;
    if (int'(d) > DATA_W_MAX) return DATA_W_MAX;
    return int'(d);
  endfunction

  // Frame as a list of bit levels: start, data LSB first, optional parity.
  function automatic logic [15:0] frame_bits(input logic [DATA_W_MAX-1:0] data,
                                             input logic [CW-1:0] d, input logic [2:0] par);
    int n, ones;
    logic [15:0] b;
    n = eff_dbits(d); ones = 0; b = '0;
    for (int i = 0; i < n; i++) begin
      b[i+1] = data[i];
      ones += int'(data[i]);
    end
    if (par[2]) begin
      case (par[1:0])
        2'b00:   b[n+1] = (ones % 2 == 0);
        2'b01:   b[n+1] = (ones % 2 == 1);
        2'b10:   b[n+1] = 1'b1;
        default: b[n+1] = 1'b0;
      endcase
    end
    return b;
  endfunction

  function automatic int frame_nbits(input logic [CW-1:0] d, input logic [2:0] par);
    return 1 + eff_dbits(d) + (par[2] ? 1 : 0);
  endfunction

  function automatic int stop_ticks(input logic [1:0] stop);
    if (stop[1]) return 2 * OVS;
    if (stop[0]) return (3 * OVS) / 2;
    return OVS;
  endfunction

  function automatic logic exp_ready();
    return tx_en && !cfg_brk &&
           ((m_mode == M_IDLE) || ((m_mode == M_FRAME) && os_tick && (m_ticks == m_total - 1)));
  endfunction

  function automatic logic exp_txd();
    if (m_mode == M_IDLE) return 1'b1;
    if (m_mode == M_BRK)  return 1'b0;
    if (m_ticks < m_nb * OVS) return m_bits[m_ticks / OVS];
    return 1'b1;
  endfunction

  // Reference model: position within the current frame counted in os_ticks.
  always @(posedge pclk) begin
    started <= 1'b1;
    if (preset) begin
      m_mode <= M_IDLE; m_ticks <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (s_valid && exp_ready()) begin
            m_mode <= M_FRAME; m_ticks <= 0;
            m_bits <= frame_bits(s_data, cfg_dbits, cfg_par);
            m_nb <= frame_nbits(cfg_dbits, cfg_par);
            m_total <= frame_nbits(cfg_dbits, cfg_par) * OVS + stop_ticks(cfg_stop);
          end else if (cfg_brk && tx_en) begin
            m_mode <= M_BRK;
          end
        end
        M_FRAME: begin
          if (!tx_en) begin
            m_mode <= M_IDLE; m_ticks <= 0;
          end else if (os_tick) begin
            if (m_ticks == m_total - 1) begin
              m_done <= 1'b1;
              if (s_valid && exp_ready()) begin
                m_ticks <= 0;
                m_bits <= frame_bits(s_data, cfg_dbits, cfg_par);
                m_nb <= frame_nbits(cfg_dbits, cfg_par);
                m_total <= frame_nbits(cfg_dbits, cfg_par) * OVS + stop_ticks(cfg_stop);
              end else begin
                m_mode <= M_IDLE; m_ticks <= 0;
              end
            end else begin
              m_ticks <= m_ticks + 1;
            end
          end
        end
        default: if (!(cfg_brk && tx_en)) m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge pclk) begin
    if (started) begin
      checkOutput("model_txd", txd, exp_txd());
      checkOutput("model_busy", busy, m_mode != M_IDLE);
      checkOutput("model_tx_done", tx_done, m_done);
      checkOutput("model_s_ready", s_ready, exp_ready());
    end
  end

  // Sends one word from idle with os_tick every cycle; cycle j=1 is the first after accept.
  task automatic run_frame(input string name, input logic [DATA_W_MAX-1:0] data,
                           input logic [CW-1:0] dbits, input logic [2:0] par, input logic [1:0] stop,
                           input logic [15:0] exp, input int nb, input int done_j);
    applyStimulus(1'b1, 1'b0, dbits, par, stop, 1'b1, data);
    os_tick = 1'b1;
    @(posedge pclk); #1;
    s_valid = 1'b0;
    for (int j = 1; j <= done_j + 1; j++) begin
      @(negedge pclk);
      if ((j % OVS == OVS / 2) && (j / OVS < nb)) checkOutput({name, "_bit"}, txd, exp[j / OVS]);
      if (j == done_j - 1) checkOutput({name, "_done_early"}, tx_done, 1'b0);
      if (j == done_j)     checkOutput({name, "_done"}, tx_done, 1'b1);
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    logic saw_done;
    int tick_mode, brk_cnt;
    preset = 1'b1; os_tick = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd8, 3'b000, 2'b00, 1'b0, '0);
    @(posedge pclk); #1;
    @(negedge pclk);
    checkOutput("reset_txd", txd, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_tx_done", tx_done, 1'b0);
    checkOutput("reset_ready_disabled", s_ready, 1'b0);
    @(posedge pclk); #1;
    tx_en = 1'b1;
    @(negedge pclk);
    checkOutput("reset_ready_enabled", s_ready, 1'b1);
    @(posedge pclk); #1;
    preset = 1'b0; os_tick = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end

    run_frame("f8n1_a5", 9'h0A5, 4'd8, 3'b000, 2'b00, 16'b1101001010, 10, 161);
    run_frame("f7e2_35", 9'h035, 4'd7, 3'b101, 2'b10, 16'b1001101010, 10, 177);
    run_frame("f7o15_35", 9'h035, 4'd7, 3'b100, 2'b01, 16'b1101101010, 10, 169);
    run_frame("f_dbits3", 9'h1F5, 4'd3, 3'b000, 2'b00, 16'b1101010, 7, 113);
    run_frame("f_dbits12", 9'h1A5, 4'd12, 3'b000, 2'b00, 16'b11101001010, 11, 177);

    // Three words back to back, 5N1.
    applyStimulus(1'b1, 1'b0, 4'd5, 3'b000, 2'b00, 1'b1, 9'h015);
    @(posedge pclk); #1;
    s_data = 9'h00A;
    for (int j = 1; j <= 340; j++) begin
      @(negedge pclk);
      if (j == 111 || j == 113 || j == 223) checkOutput("b2b_ready_low", s_ready, 1'b0);
      if (j == 112 || j == 224) checkOutput("b2b_ready_pulse", s_ready, 1'b1);
      if (j == 113 || j == 225) begin
        checkOutput("b2b_no_gap", txd, 1'b0);
        checkOutput("b2b_done", tx_done, 1'b1);
      end
      if (j == 337) checkOutput("b2b_last_done", tx_done, 1'b1);
      @(posedge pclk); #1;
      if (j == 112) s_data = 9'h01F;
      if (j == 224) s_valid = 1'b0;
    end

    // tx_en dropped during data bit 3, then a full resend.
    applyStimulus(1'b1, 1'b0, 4'd8, 3'b000, 2'b00, 1'b1, 9'h0A5);
    @(posedge pclk); #1;
    s_valid = 1'b0;
    saw_done = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge pclk);
      if (j == 70) checkOutput("abort_busy_before", busy, 1'b1);
      if (j == 71) begin
        checkOutput("abort_txd", txd, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
      end
      if (tx_done) saw_done = 1'b1;
      @(posedge pclk); #1;
      if (j == 69) tx_en = 1'b0;
      if (j == 70) tx_en = 1'b1;
    end
    checkOutput("abort_no_done", saw_done, 1'b0);
    run_frame("resend_a5", 9'h0A5, 4'd8, 3'b000, 2'b00, 16'b1101001010, 10, 161);

    // Break requested mid-frame.
    applyStimulus(1'b1, 1'b0, 4'd8, 3'b000, 2'b00, 1'b1, 9'h0A5);
    @(posedge pclk); #1;
    s_data = 9'h133;
    for (int j = 1; j <= 205; j++) begin
      @(negedge pclk);
      if (j == 100) checkOutput("brk_frame_busy", busy, 1'b1);
      if (j == 160) checkOutput("brk_ready_at_boundary", s_ready, 1'b0);
      if (j == 161) begin
        checkOutput("brk_done", tx_done, 1'b1);
        checkOutput("brk_idle_txd", txd, 1'b1);
      end
      if (j == 162) checkOutput("brk_txd_low", txd, 1'b0);
      if (j == 190) begin
        checkOutput("brk_hold_txd", txd, 1'b0);
        checkOutput("brk_hold_ready", s_ready, 1'b0);
        checkOutput("brk_hold_done", tx_done, 1'b0);
      end
      if (j == 201) checkOutput("brk_release_txd", txd, 1'b1);
      @(posedge pclk); #1;
      if (j == 39)  cfg_brk = 1'b1;
      if (j == 198) s_valid = 1'b0;
      if (j == 199) cfg_brk = 1'b0;
    end

    // preset during the parity bit.
    applyStimulus(1'b1, 1'b0, 4'd7, 3'b101, 2'b10, 1'b1, 9'h035);
    @(posedge pclk); #1;
    s_valid = 1'b0;
    for (int j = 1; j <= 140; j++) begin
      @(negedge pclk);
      if (j == 130) checkOutput("preset_parity_txd", txd, 1'b0);
      if (j == 136) begin
        checkOutput("preset_txd", txd, 1'b1);
        checkOutput("preset_busy", busy, 1'b0);
      end
      @(posedge pclk); #1;
      if (j == 134) preset = 1'b1;
      if (j == 135) preset = 1'b0;
    end

    // preset wins over a coincident accept.
    preset = 1'b1; s_valid = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; s_valid = 1'b0;
    @(negedge pclk);
    checkOutput("preset_vs_accept_busy", busy, 1'b0);
    checkOutput("preset_vs_accept_txd", txd, 1'b1);
    @(posedge pclk); #1;

    // Randomised traffic, ticks, configuration, aborts, breaks and resets.
    tick_mode = 0; brk_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      if (c % 2000 == 0) tick_mode = $urandom_range(0, 2);
      os_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(0, tick_mode) == 0);
      if ($urandom_range(0, 255) == 0) begin
        cfg_dbits = CW'($urandom_range(0, 15));
        cfg_par   = 3'($urandom_range(0, 7));
        cfg_stop  = 2'($urandom_range(0, 3));
      end
      s_valid = ($urandom_range(0, 2) == 0);
      s_data  = DATA_W_MAX'($urandom);
      tx_en   = ($urandom_range(0, 399) != 0);
      if (brk_cnt > 0) brk_cnt--;
      else if ($urandom_range(0, 599) == 0) brk_cnt = $urandom_range(5, 60);
      cfg_brk = (brk_cnt > 0);
      preset  = ($urandom_range(0, 2999) == 0);
      @(posedge pclk); #1;
    end

    preset = 1'b0; s_valid = 1'b0; cfg_brk = 1'b0;
    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
